// File: rtl/intra_pkg.sv
// Shared types and constants for the intra reconstruction path: level/residual type,
// dequant scale table, datapath width default and residual saturation bounds.
package intra_pkg;

    localparam int DW_DEF  = 32;
    localparam int NCOEF   = 16;
    localparam int RES_MIN = -128;
    localparam int RES_MAX = 127;

    typedef logic signed [7:0] level_t;

    typedef enum logic [1:0] {
        CLS_EE  = 2'd0,
        CLS_OO  = 2'd1,
        CLS_MIX = 2'd2
    } cls_t;

    // Rows indexed by QP%6, columns by coefficient class
    localparam logic [4:0] VTAB [0:5][0:2] = '{
        '{5'd10, 5'd16, 5'd13},
        '{5'd11, 5'd18, 5'd14},
        '{5'd13, 5'd20, 5'd16},
        '{5'd14, 5'd23, 5'd18},
        '{5'd16, 5'd25, 5'd20},
        '{5'd18, 5'd29, 5'd23}
    };

    function automatic cls_t coef_class(input int k);
        logic row_odd;
        logic col_odd;
        row_odd = k[2];
        col_odd = k[0];
        if (!row_odd && !col_odd)
            return CLS_EE;
        else if (row_odd && col_odd)
            return CLS_OO;
        else
            return CLS_MIX;
    endfunction

endpackage

// File: rtl/itx_butterfly4.sv
// Combinational 4-point inverse integer transform butterfly; zero latency, no flow control.
module itx_butterfly4 #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a0,
    input  logic signed [W-1:0] a1,
    input  logic signed [W-1:0] a2,
    input  logic signed [W-1:0] a3,
    output logic signed [W-1:0] o0,
    output logic signed [W-1:0] o1,
    output logic signed [W-1:0] o2,
    output logic signed [W-1:0] o3
);

    logic signed [W-1:0] e, f, g, h;

    always_comb begin
        e  = a0 + a2;
        f  = a0 - a2;
        g  = (a1 >>> 1) - a3;
        h  = a1 + (a3 >>> 1);
        o0 = e + h;
        o1 = f + g;
        o2 = f - g;
        o3 = e - h;
    end

endmodule

// File: rtl/inv_transformcoder.sv
// 4x4 dequant + inverse integer transform, 1 block/cycle, 4 enabled edges of latency.
// enable=0 freezes every stage, valid bit and output; no other backpressure.
module inv_transformcoder
    import intra_pkg::*;
#(
    parameter int NSTAGE = 4,
    parameter int DW     = DW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [5:0]        QP,
    input  logic              in_valid,
    input  level_t [15:0]     coeffs,
    output logic              out_valid,
    output logic              pipeline_full,
    output level_t [15:0]     residuals
);

    logic signed [DW-1:0] w_d   [NCOEF];
    logic signed [DW-1:0] w_q   [NCOEF];
    logic signed [DW-1:0] row_d [NCOEF];
    logic signed [DW-1:0] row_q [NCOEF];
    logic signed [DW-1:0] col_d [NCOEF];
    logic signed [DW-1:0] col_q [NCOEF];
    level_t [15:0]        res_d;
    level_t [15:0]        res_q;
    logic [NSTAGE-1:0]    vld_q;
    logic                 full_q;

    logic [2:0] qp_mod;
    logic [3:0] qp_div;
    logic [3:0] shamt;

    // Shift is capped so an out-of-range QP cannot overflow the datapath
    always_comb begin
        logic signed [DW-1:0] cx;
        logic signed [DW-1:0] vx;
        cx     = '0;
        vx     = '0;
        qp_mod = 3'(QP % 6'd6);
        qp_div = 4'(QP / 6'd6);
        shamt  = (qp_div > 4'd8) ? 4'd8 : qp_div;
        for (int k = 0; k < NCOEF; k++) begin
            cx     = {{(DW-8){coeffs[k][7]}}, coeffs[k]};
            vx     = DW'(VTAB[int'(qp_mod)][int'(coef_class(k))]);
            w_d[k] = (cx * vx) <<< shamt;
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        itx_butterfly4 #(.W(DW)) u_row (
            .a0(w_q[4*r+0]),   .a1(w_q[4*r+1]),   .a2(w_q[4*r+2]),   .a3(w_q[4*r+3]),
            .o0(row_d[4*r+0]), .o1(row_d[4*r+1]), .o2(row_d[4*r+2]), .o3(row_d[4*r+3])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        itx_butterfly4 #(.W(DW)) u_col (
            .a0(row_q[c]),   .a1(row_q[4+c]),   .a2(row_q[8+c]),   .a3(row_q[12+c]),
            .o0(col_d[c]),   .o1(col_d[4+c]),   .o2(col_d[8+c]),   .o3(col_d[12+c])
        );
    end

    // Floor rounding by 64, then clamp to the 8-bit residual range
    always_comb begin
        logic signed [DW-1:0] t;
        t     = '0;
        res_d = '0;
        for (int k = 0; k < NCOEF; k++) begin
            t = (col_q[k] + DW'(32)) >>> 6;
            if (t > RES_MAX)
                res_d[k] = 8'sd127;
            else if (t < RES_MIN)
                res_d[k] = -8'sd128;
            else
                res_d[k] = t[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCOEF; k++) begin
                w_q[k]   <= '0;
                row_q[k] <= '0;
                col_q[k] <= '0;
            end
            res_q  <= '0;
            vld_q  <= '0;
            full_q <= 1'b0;
        end else if (enable) begin
            w_q   <= w_d;
            row_q <= row_d;
            col_q <= col_d;
            vld_q <= {vld_q[NSTAGE-2:0], in_valid};
            // Residuals only move for real blocks so bubbles keep the last result visible
            if (vld_q[NSTAGE-2]) begin
                res_q  <= res_d;
                full_q <= 1'b1;
            end
        end
    end

    assign out_valid     = vld_q[NSTAGE-1];
    assign pipeline_full = full_q;
    assign residuals     = res_q;

endmodule

// File: tb/tb_inv_transformcoder.sv
module tb_inv_transformcoder;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [5:0]        qp;
    logic              in_valid;
    logic [15:0][7:0]  coeffs;
    logic              out_valid;
    logic              pipeline_full;
    logic [15:0][7:0]  residuals;

    always #5 clk = ~clk;

    inv_transformcoder dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .QP            (qp),
        .in_valid      (in_valid),
        .coeffs        (coeffs),
        .out_valid     (out_valid),
        .pipeline_full (pipeline_full),
        .residuals     (residuals)
    );

    typedef struct {
        logic [5:0] qp;
        int         pos;
        int         val;
        int         exp[4];
        bit         colwise;
    } vec_t;

    localparam int NV = 10;
    vec_t tv[NV];

    int total = 0;
    int bad   = 0;
    int nvalid;
    logic [127:0] q[$];
    logic [127:0] last_res;
    logic         last_ov;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] expand(input vec_t v);
        logic [15:0][7:0] r;
        for (int k = 0; k < 16; k++)
            r[k] = 8'(v.colwise ? v.exp[k/4] : v.exp[k%4]);
        return r;
    endfunction

    function automatic logic [127:0] dc16(input int x);
        logic [15:0][7:0] r;
        for (int k = 0; k < 16; k++) r[k] = 8'(x);
        return r;
    endfunction

    function automatic logic [127:0] stim(input int pos, input int val);
        logic [15:0][7:0] c;
        c      = '0;
        c[pos] = 8'(val);
        return c;
    endfunction

    task automatic drive(input logic v, input logic [5:0] p, input logic [127:0] c,
                         input logic [127:0] e);
        in_valid = v;
        qp       = p;
        coeffs   = c;
        if (v && enable && !reset) q.push_back(e);
    endtask

    task automatic sample();
        if (reset) begin
            last_res = residuals;
            last_ov  = out_valid;
            return;
        end
        if (!enable) begin
            chk("stall_valid", 128'(out_valid), 128'(last_ov));
            chk("stall_res", residuals, last_res);
        end else if (out_valid) begin
            nvalid++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out_valid got=1 exp=0");
            end else begin
                chk("residuals", residuals, q.pop_front());
            end
        end else begin
            chk("bubble_hold", residuals, last_res);
        end
        last_res = residuals;
        last_ov  = out_valid;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        sample();
    endtask

    initial begin
        int first;
        int b;
        logic pat[8];
        int dexp[6];

        tv[0] = '{6'd28, 0,    1, '{4, 4, 4, 4},         1'b0};
        tv[1] = '{6'd28, 1,    1, '{5, 3, -2, -5},       1'b0};
        tv[2] = '{6'd51, 0,  127, '{127, 127, 127, 127}, 1'b0};
        tv[3] = '{6'd51, 0, -128, '{-128, -128, -128, -128}, 1'b0};
        tv[4] = '{6'd28, 0,   -1, '{-4, -4, -4, -4},     1'b0};
        tv[5] = '{6'd0,  0,    7, '{1, 1, 1, 1},         1'b0};
        tv[6] = '{6'd34, 2,    1, '{8, -8, -8, 8},       1'b0};
        tv[7] = '{6'd12, 3,   -2, '{-1, 2, -2, 1},       1'b0};
        tv[8] = '{6'd63, 0,    1, '{56, 56, 56, 56},     1'b0};
        tv[9] = '{6'd28, 4,    1, '{5, 3, -2, -5},       1'b1};
        dexp  = '{4, 16, 12, 32, 20, 48};

        // Reset held with valid input present
        reset    = 1'b1;
        enable   = 1'b1;
        in_valid = 1'b1;
        qp       = 6'd28;
        coeffs   = stim(0, 1);
        last_res = '0;
        last_ov  = 1'b0;
        nvalid   = 0;
        cyc();
        cyc();
        chk("reset_res", residuals, '0);
        chk("reset_valid", 128'(out_valid), '0);
        chk("reset_full", 128'(pipeline_full), '0);

        // Back-to-back directed table, latency and pipeline_full rise
        reset = 1'b0;
        first = -1;
        for (int i = 0; i < NV + 8; i++) begin
            if (i < NV)
                drive(1'b1, tv[i].qp, stim(tv[i].pos, tv[i].val), expand(tv[i]));
            else
                drive(1'b0, 6'd0, stim(0, 0), '0);
            cyc();
            if (i == 2) chk("full_before", 128'(pipeline_full), '0);
            if (out_valid && first < 0) begin
                first = i + 1;
                chk("full_rise", 128'(pipeline_full), 128'(1));
            end
        end
        chk("latency", 128'(first), 128'(4));
        chk("count_table", 128'(nvalid), 128'(NV));

        // Bubbles: out_valid follows in_valid 4 cycles later
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (pat[i])
                drive(1'b1, tv[i].qp, stim(tv[i].pos, tv[i].val), expand(tv[i]));
            else
                drive(1'b0, 6'd51, stim(5, 100), '0);
            cyc();
            chk("bubble_valid", 128'(out_valid), 128'((i >= 3 && i - 3 < 8) ? pat[i-3] : 1'b0));
        end

        // Stream of 6 DC blocks with alternating QP and a 3-cycle stall
        nvalid = 0;
        b      = 0;
        for (int i = 0; i < 18; i++) begin
            enable = !(i >= 5 && i < 8);
            if (b < 6)
                drive(1'b1, (b % 2 == 0) ? 6'd28 : 6'd34, stim(0, b + 1), dc16(dexp[b]));
            else
                drive(1'b0, 6'd0, stim(0, 0), '0);
            if (enable && b < 6) b++;
            cyc();
        end
        enable = 1'b1;
        chk("count_stream", 128'(nvalid), 128'(6));
        chk("queue_empty", 128'(q.size()), '0);

        // Reset with three blocks in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'd28, stim(0, 3), dc16(12));
            cyc();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        cyc();
        reset = 1'b0;
        q.delete();
        nvalid = 0;
        repeat (8) cyc();
        chk("flush_valid", 128'(nvalid), '0);
        chk("flush_res", residuals, '0);
        chk("flush_full", 128'(pipeline_full), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_transformcoder.md
Name: inv_transformcoder

Overview:
- Reconstruction-side counterpart of the forward transform coder: takes one 4x4 block of quantized levels per cycle, dequantizes by QP and applies the 4x4 integer inverse transform.
- Produces signed 8-bit residuals for the reconstructor.
- One instance serves luma 4x4. Four instances per chroma component serve the 8x8 quadrants.
- Fully pipelined: throughput 1 block/cycle, fixed latency.

Parameters:
- NSTAGE, 4, pipeline depth (fixed; changing it is not supported, exposed for bench use only)
- DW, 32, internal signed datapath width after dequant

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  pipeline advance; low = every stage holds
- QP  input  6  quantization parameter, 0..51, sampled with the block at stage 1
- in_valid  input  1  coeffs carry a block this cycle
- coeffs  input  16 x signed 8  quantized levels, index k = 4*row + col, row 0 = k 0..3
- out_valid  output  1  residuals valid
- pipeline_full  output  1  sticky; high once the first valid block reaches the output
- residuals  output  16 x signed 8  reconstructed residuals, same indexing as coeffs

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset:
  - all stage registers, residuals, out_valid and pipeline_full go to 0.
  - Reset has priority over enable.
  - Reset mid-operation discards all in-flight blocks; no out_valid pulses follow from them.
- Stage 1, dequant:
  - w[k] = coeffs[k] * v(QP%6, class) << (QP/6), computed at DW width, signed.
  - class 0: row and col both even. class 1: row and col both odd. class 2: otherwise.
  - v table, rows indexed by QP%6 = 0..5, entries {class0, class1, class2}: {10,16,13} {11,18,14} {13,20,16} {14,23,18} {16,25,20} {18,29,23}.
- Stage 2, row pass on each row (a0..a3):
  - e = a0 + a2; f = a0 - a2; g = (a1>>>1) - a3; h = a1 + (a3>>>1)
  - out = {e+h, f+g, f-g, e-h}
- Stage 3: column pass, same butterfly, applied per column.
- Stage 4: r = (x + 32) >>> 6 (arithmetic, i.e. floor), then saturate to [-128, 127].
- Latency:
  - A block with in_valid=1 at an enable=1 edge appears at residuals with out_valid=1 after exactly 4 enabled edges.
  - With enable held high, that is 4 cycles.
- Valid tracking:
  - A 4-bit valid shift register advances only when enable=1.
  - in_valid=0 inserts a bubble; residuals hold their last value and out_valid=0.
- enable=0: no stage, valid bit or output changes. out_valid holds its value, so a stall shows the same block (out_valid=1) for several cycles.
- pipeline_full:
  - Set on the first edge at which out_valid becomes 1.
  - Cleared only by reset.
- QP: per block; QP changing between consecutive blocks must be honoured.
- QP > 51: undefined input. The design must still not overflow DW, so the shift is capped at 8.
- Worst-case magnitude: 127 * 29 * 256 plus transform growth stays under 2^27, within DW.

Decomposition:
- Shared package intra_pkg:
  - residual/level typedef (signed 8)
  - the 6x3 dequant v table as a constant array
  - DW default
  - the saturation bounds -128/127
- Sub-module itx_butterfly4: combinational 4-point inverse butterfly (e/f/g/h). Instantiated 4x for rows and 4x for columns.
- The dequant stage stays inline.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 → residuals all 0, out_valid=0, pipeline_full=0. Reset pulsed while 3 blocks are in flight → no out_valid pulses afterwards.
- DC: coeffs[0]=1, rest 0, QP=28 (v=16, <<4 gives 256) → all 16 residuals = 4, out_valid high on the 4th cycle, pipeline_full rises the same cycle.
- AC: coeffs[1]=1, QP=28 (v=20, <<4 gives 320) → every row = {5, 3, -2, -5}, exercising negative floor rounding.
- Saturation:
  - coeffs[0]=127, QP=51 → all residuals 127.
  - coeffs[0]=-128, QP=51 → all residuals -128.
- Throughput/stall:
  - Stream 6 back-to-back blocks with distinct DC values and QP alternating 28/34 → 6 consecutive out_valid cycles in order.
  - Drop enable for 3 cycles mid-stream → outputs and out_valid frozen, no block lost or duplicated after resume.
- Bubbles: in_valid pattern 1,0,1,0 → out_valid pattern 1,0,1,0 delayed by 4 cycles; residuals unchanged during bubble cycles.
